// File: rtl/bpr_line_interpol_if.sv
// bpr_line_interpol_if: input pixel stream with ready, plus the aligned output pixel stream
interface bpr_line_interpol_if #(
  parameter int PIX_W = 15
);
  logic             s_valid;
  logic             s_ready;
  logic             s_sof;
  logic             s_sol;
  logic             s_eol;
  logic             s_bad;
  logic [PIX_W-1:0] s_pix;
  logic             m_valid;
  logic             m_sol;
  logic             m_eol;
  logic             m_fixed;
  logic             m_unfixed;
  logic [PIX_W-1:0] m_pix;
  modport master (
    output s_valid, s_sof, s_sol, s_eol, s_bad, s_pix,
    input  s_ready, m_valid, m_sol, m_eol, m_fixed, m_unfixed, m_pix
  );
  modport slave (
    input  s_valid, s_sof, s_sol, s_eol, s_bad, s_pix,
    output s_ready, m_valid, m_sol, m_eol, m_fixed, m_unfixed, m_pix
  );
endinterface

// File: rtl/bpr_line_interpol.sv
// bpr_line_interpol: streaming 3-tap line interpolator; replaces bad pixels from good neighbours
// or applies a (1,2,1)/4 kernel, with per-frame replacement count and protocol error flag
module bpr_line_interpol #(
  parameter int PIX_W = 15,
  parameter int CNT_W = 20
) (
  input  logic               clk,
  input  logic               arstn,
  input  logic               cen,
  input  logic [1:0]         mode,
  bpr_line_interpol_if.slave io,
  output logic [CNT_W-1:0]   bad_cnt,
  output logic               err_proto
);
  typedef enum logic [1:0] {EMPTY, HOLD, FLUSH} state_t;
  state_t           state, state_nx;
  logic [PIX_W-1:0] l_val, c_val, lv, rv, pix_o;
  logic             l_bad, l_pres, c_bad, c_sol, c_eol;
  logic [1:0]       line_mode;
  logic [CNT_W-1:0] count;
  logic             xfer, emit, r_pres, new_sol, gl, gr, rep, cnt_inc;
  logic [PIX_W:0]   sum_lr;
  logic [PIX_W+1:0] sum_k;
  always_comb begin
    xfer     = io.s_valid & io.s_ready & cen;
    emit     = cen & ((state == FLUSH) | ((state == HOLD) & xfer));
    r_pres   = (state == HOLD) & ~io.s_sol;
    new_sol  = xfer & ((state == EMPTY) | io.s_sol);
    state_nx = (state == FLUSH) ? EMPTY : xfer ? (io.s_eol ? FLUSH : HOLD) : state;
    gl       = l_pres & ~l_bad;
    gr       = r_pres & ~io.s_bad;
    lv       = l_pres ? l_val : c_val;
    rv       = r_pres ? io.s_pix : c_val;
    sum_lr   = {1'b0, l_val} + {1'b0, io.s_pix};
    sum_k    = {2'b0, lv} + {1'b0, c_val, 1'b0} + {2'b0, rv};
    rep      = (line_mode == 2'd1) & c_bad;
    pix_o    = (line_mode == 2'd2) ? sum_k[PIX_W+1:2] :
               !rep      ? c_val :
               (gl & gr) ? sum_lr[PIX_W:1] :
               gl        ? l_val :
               gr        ? io.s_pix : c_val;
    cnt_inc  = emit & rep;
  end
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state        <= EMPTY;
      io.s_ready   <= 1'b1;
      io.m_valid   <= 1'b0;
      io.m_pix     <= '0;
      io.m_sol     <= 1'b0;
      io.m_eol     <= 1'b0;
      io.m_fixed   <= 1'b0;
      io.m_unfixed <= 1'b0;
      l_val        <= '0;
      l_bad        <= 1'b0;
      l_pres       <= 1'b0;
      c_val        <= '0;
      c_bad        <= 1'b0;
      c_sol        <= 1'b0;
      c_eol        <= 1'b0;
      line_mode    <= 2'd0;
      count        <= '0;
      bad_cnt      <= '0;
      err_proto    <= 1'b0;
    end else if (cen) begin
      state      <= state_nx;
      io.s_ready <= state_nx != FLUSH;
      io.m_valid <= emit;
      if (emit) begin
        io.m_pix     <= pix_o;
        io.m_sol     <= c_sol;
        io.m_eol     <= c_eol;
        io.m_fixed   <= rep & (gl | gr);
        io.m_unfixed <= rep & ~(gl | gr);
      end
      if (xfer) begin
        l_val  <= c_val;
        l_bad  <= c_bad;
        l_pres <= r_pres;
        c_val  <= io.s_pix;
        c_bad  <= io.s_bad;
        c_sol  <= (state == EMPTY) | io.s_sol;
        c_eol  <= io.s_eol;
      end
      if (new_sol) line_mode <= mode;
      // a line must open with SOL and must not be reopened before its EOL
      if (xfer & ((state == EMPTY) ? ~io.s_sol : io.s_sol)) err_proto <= 1'b1;
      if (xfer & io.s_sof) begin
        bad_cnt <= count;
        count   <= {{(CNT_W-1){1'b0}}, cnt_inc};
      end else if (cnt_inc & ~&count) begin
        count <= count + 1'b1;
      end
    end
  end
endmodule
